// File: rtl/branch_predict_ctrl_if.sv
// Pipeline-side bus of the branch predictor: IF lookup, EX resolution,
// stall input, and the redirect/flush/performance outputs.
interface branch_predict_ctrl_if;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_BA;
    logic [31:0] ex_target;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_pred_taken, ex_BA, ex_target, stall,
        input  if_pred_taken, redirect, redirect_pc, flush, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_pred_taken, ex_BA, ex_target, stall,
        output if_pred_taken, redirect, redirect_pc, flush, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped 2-bit saturating-counter branch predictor with a small FSM
// that sequences PC redirect and pipeline flush after a misprediction.
module branch_predict_ctrl #(
    parameter int IDX_BITS     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int FCNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                redirect_q;
    logic [31:0]         redirect_pc_q;
    logic                flush_q;
    logic [15:0]         branch_cnt_q, branch_cnt_d;
    logic [15:0]         mispred_cnt_q, mispred_cnt_d;

    logic                res;
    logic                mis;
    logic [IDX_BITS-1:0] ex_idx;
    logic [IDX_BITS-1:0] if_idx;
    logic [ENTRIES-1:0]  pred_msb;
    logic                unused_pc_bits;

    assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
    assign if_idx = bus.if_pc[IDX_BITS+1:2];
    assign unused_pc_bits = ^{bus.if_pc[31:IDX_BITS+2], bus.if_pc[1:0]};

    // Wrong-path branches arriving during FLUSH are dropped by the state term.
    assign res = bus.ex_valid & ~bus.stall & (state_q == IDLE);
    assign mis = res & (bus.ex_BA != bus.ex_pred_taken);

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (res && (ex_idx == IDX_BITS'(gi))) begin
                    if (bus.ex_BA) begin
                        if (cnt_q != 2'b11) cnt_d = cnt_q + 2'd1;
                    end else begin
                        if (cnt_q != 2'b00) cnt_d = cnt_q - 2'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) cnt_q <= 2'b01;
                else     cnt_q <= cnt_d;
            end

            assign pred_msb[gi] = cnt_q[1];
        end
    endgenerate

    // Read sees the registered entry, so a same-cycle EX update is not forwarded.
    assign bus.if_pred_taken = pred_msb[if_idx];

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (res && (branch_cnt_q != 16'hFFFF))  branch_cnt_d  = branch_cnt_q + 16'd1;
        if (mis && (mispred_cnt_q != 16'hFFFF)) mispred_cnt_d = mispred_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= 16'd0;
            mispred_cnt_q <= 16'd0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fcnt_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            flush_q       <= 1'b0;
        end else if (!bus.stall) begin
            case (state_q)
                IDLE: begin
                    if (mis) begin
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= bus.ex_BA ? bus.ex_target : (bus.ex_pc + 32'd4);
                        flush_q       <= 1'b1;
                        state_q       <= FLUSH;
                        fcnt_q        <= FCNT_INIT;
                    end
                end
                FLUSH: begin
                    redirect_q <= 1'b0;
                    if (fcnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        fcnt_q <= fcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign bus.flush       = flush_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: a per-cycle vector table plus
// hand-written stall and reset-during-flush sequences.
module tb_branch_predict_ctrl;
    logic clk;
    logic rst;

    branch_predict_ctrl_if bus ();

    branch_predict_ctrl #(
        .IDX_BITS    (4),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        pred;
        logic        ba;
        logic [31:0] tgt;
        logic [31:0] ifpc;
        logic        exp_pt;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_flush;
        logic [15:0] exp_b;
        logic [15:0] exp_m;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic valid, logic [31:0] pc, logic pred, logic ba,
                                logic [31:0] tgt, logic [31:0] ifpc, logic exp_pt,
                                logic exp_redir, logic [31:0] exp_rpc, logic exp_flush,
                                logic [15:0] exp_b, logic [15:0] exp_m);
        vec_t v;
        v.valid = valid; v.pc = pc; v.pred = pred; v.ba = ba; v.tgt = tgt;
        v.ifpc = ifpc; v.exp_pt = exp_pt; v.exp_redir = exp_redir; v.exp_rpc = exp_rpc;
        v.exp_flush = exp_flush; v.exp_b = exp_b; v.exp_m = exp_m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic [31:0] pc, input logic pred,
                         input logic ba, input logic [31:0] tgt, input logic stl);
        bus.ex_valid      = valid;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pred;
        bus.ex_BA         = ba;
        bus.ex_target     = tgt;
        bus.stall         = stl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic redir, input logic [31:0] rpc,
                            input logic fl, input logic [15:0] b, input logic [15:0] m);
        chk({tag, ".redirect"}, 32'(bus.redirect), 32'(redir));
        if (redir) chk({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
        chk({tag, ".flush"}, 32'(bus.flush), 32'(fl));
        chk({tag, ".branch_cnt"}, 32'(bus.branch_cnt), 32'(b));
        chk({tag, ".mispred_cnt"}, 32'(bus.mispred_cnt), 32'(m));
    endtask

    initial begin
        // Per-cycle vectors: inputs held for one cycle; prediction checked in
        // that cycle, registered outputs checked just after the following edge.
        vq.push_back(mk(1, 32'h100, 0, 0, 32'h0,   32'h100, 0, 0, 32'h0,  0, 1, 0));  // correct NT
        vq.push_back(mk(1, 32'h104, 0, 1, 32'h80,  32'h104, 0, 1, 32'h80, 1, 2, 1));  // taken mispredict
        vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h104, 1, 0, 32'h0,  1, 2, 1));
        vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 0, 32'h0,  0, 2, 1));
        vq.push_back(mk(1, 32'hFFFFFFFC, 1, 0, 32'h1234, 32'hFFFFFFFC, 0, 1, 32'h0, 1, 3, 2)); // wrap
        vq.push_back(mk(1, 32'h108, 1, 0, 32'h40,  32'h108, 0, 0, 32'h0,  1, 3, 2));  // wrong path
        vq.push_back(mk(1, 32'h108, 0, 1, 32'h40,  32'h108, 0, 0, 32'h0,  0, 3, 2));  // wrong path
        vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h108, 0, 0, 32'h0,  0, 3, 2));
        vq.push_back(mk(1, 32'h10C, 1, 1, 32'h0,   32'h10C, 0, 0, 32'h0,  0, 4, 2));  // train taken x4
        vq.push_back(mk(1, 32'h10C, 1, 1, 32'h0,   32'h10C, 1, 0, 32'h0,  0, 5, 2));
        vq.push_back(mk(1, 32'h10C, 1, 1, 32'h0,   32'h10C, 1, 0, 32'h0,  0, 6, 2));
        vq.push_back(mk(1, 32'h10C, 1, 1, 32'h0,   32'h10C, 1, 0, 32'h0,  0, 7, 2));
        vq.push_back(mk(1, 32'h10C, 0, 0, 32'h0,   32'h10C, 1, 0, 32'h0,  0, 8, 2));  // 11 -> 10
        vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h10C, 1, 0, 32'h0,  0, 8, 2));
        vq.push_back(mk(1, 32'h10C, 0, 0, 32'h0,   32'h10C, 1, 0, 32'h0,  0, 9, 2));  // 10 -> 01
        vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h10C, 0, 0, 32'h0,  0, 9, 2));
        vq.push_back(mk(1, 32'h100, 1, 1, 32'h0,   32'h100, 0, 0, 32'h0,  0, 10, 2)); // 00 -> 01
        vq.push_back(mk(0, 32'h0,   0, 0, 32'h0,   32'h100, 0, 0, 32'h0,  0, 10, 2));

        rst = 1'b1;
        bus.if_pc = 32'h0;
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        repeat (2) tick();
        chk_outs("reset", 0, 32'h0, 0, 0, 0);
        for (int a = 0; a < 16; a++) begin
            bus.if_pc = 32'(a * 4);
            #1;
            chk($sformatf("reset.pred[0x%02h]", a * 4), 32'(bus.if_pred_taken), 32'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].valid, vq[i].pc, vq[i].pred, vq[i].ba, vq[i].tgt, 0);
            bus.if_pc = vq[i].ifpc;
            #1;
            chk($sformatf("vec%0d.pred", i), 32'(bus.if_pred_taken), 32'(vq[i].exp_pt));
            tick();
            chk_outs($sformatf("vec%0d", i), vq[i].exp_redir, vq[i].exp_rpc,
                     vq[i].exp_flush, vq[i].exp_b, vq[i].exp_m);
            $display("vec%0d: valid=%0d pc=0x%08h pred=%0d ba=%0d -> redirect=%0d rpc=0x%08h flush=%0d b=%0d m=%0d",
                     i, vq[i].valid, vq[i].pc, vq[i].pred, vq[i].ba, bus.redirect,
                     bus.redirect_pc, bus.flush, bus.branch_cnt, bus.mispred_cnt);
        end

        // Stall in IDLE: a would-be mispredict must not resolve.
        drive(1, 32'h110, 0, 1, 32'h200, 1);
        tick();
        chk_outs("stall_idle", 0, 32'h0, 0, 10, 2);
        $display("stall_idle: redirect=%0d flush=%0d b=%0d", bus.redirect, bus.flush, bus.branch_cnt);

        // Mispredict in cycle N, then 3 stalled cycles.
        drive(1, 32'h110, 0, 1, 32'h200, 0);
        tick();
        chk_outs("stall_mis", 1, 32'h200, 1, 11, 3);
        for (int s = 0; s < 3; s++) begin
            drive(1, 32'h114, 1, 0, 32'h0, 1);
            tick();
            chk_outs($sformatf("stall_hold%0d", s), 1, 32'h200, 1, 11, 3);
            $display("stall_hold%0d: redirect=%0d rpc=0x%08h flush=%0d", s, bus.redirect,
                     bus.redirect_pc, bus.flush);
        end
        drive(1, 32'h114, 1, 0, 32'h0, 0);
        tick();
        chk_outs("stall_rel0", 0, 32'h0, 1, 11, 3);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        tick();
        chk_outs("stall_rel1", 0, 32'h0, 0, 11, 3);
        $display("stall_release: redirect=%0d flush=%0d b=%0d m=%0d", bus.redirect, bus.flush,
                 bus.branch_cnt, bus.mispred_cnt);

        // Reset in the middle of a flush aborts it; a branch then resolves at once.
        drive(1, 32'h118, 1, 0, 32'h0, 0);
        tick();
        chk_outs("rstflush_mis", 1, 32'h11C, 1, 12, 4);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_outs("rstflush_rst", 0, 32'h0, 0, 0, 0);
        drive(1, 32'h104, 0, 1, 32'h300, 0);
        bus.if_pc = 32'h104;
        #1;
        chk("rstflush.pred", 32'(bus.if_pred_taken), 32'h0);
        tick();
        chk_outs("rstflush_after", 1, 32'h300, 1, 1, 1);
        $display("rstflush: redirect=%0d rpc=0x%08h flush=%0d b=%0d m=%0d", bus.redirect,
                 bus.redirect_pc, bus.flush, bus.branch_cnt, bus.mispred_cnt);
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
